// File: rtl/ps2_receptor_teclado.sv
// ps2_receptor_teclado
//   PS/2 keyboard receiver with a show-ahead scan-code FIFO feeding the CPU
//   input stage. Raw ps2_clk/ps2_data are synchronized, ps2_clk is glitch
//   filtered, frames (start, 8 data LSB-first, odd parity, stop) are decoded
//   and good bytes are queued. The CPU pops one byte per rd_en pulse.
//
//   Optional feature macro: PS2_BREAK_FILTER_EN
//     defined   -> 0xF0 and the byte following it are not queued
//     undefined -> every good byte is queued
//
// Ports
//   Clock      in   board clock, rising edge
//   Reset_n    in   asynchronous active-low reset
//   ps2_clk    in   raw keyboard clock (asynchronous)
//   ps2_data   in   raw keyboard data (asynchronous)
//   rd_en      in   one-cycle pop strobe
//   clear_err  in   clears the sticky overflow flag
//   data_out   out  FIFO head byte, 0x00 when empty
//   valid      out  FIFO non-empty
//   count      out  FIFO occupancy
//   overflow   out  sticky: a byte was dropped on a full FIFO
//   frame_err  out  one-cycle pulse per rejected or timed-out frame
module ps2_receptor_teclado #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                            Clock,
    input  logic                            Reset_n,
    input  logic                            ps2_clk,
    input  logic                            ps2_data,
    input  logic                            rd_en,
    input  logic                            clear_err,
    output logic [7:0]                      data_out,
    output logic                            valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
    output logic                            overflow,
    output logic                            frame_err
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [1:0]    r_clk_sync;
    logic [1:0]    r_data_sync;
    logic [FW-1:0] r_filt_cnt;
    logic          r_filt_clk;
    logic          r_filt_clk_d;
    logic          r_fall;
    logic          r_fall_data;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_clk_sync   <= '1;
            r_data_sync  <= '1;
            r_filt_cnt   <= '0;
            r_filt_clk   <= 1'b1;
            r_filt_clk_d <= 1'b1;
            r_fall       <= 1'b0;
            r_fall_data  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
            // Count consecutive samples that disagree with the filtered level;
            // the FILTER_LEN-th such sample flips it.
            if (r_clk_sync[1] == r_filt_clk) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                r_filt_clk <= r_clk_sync[1];
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
            r_filt_clk_d <= r_filt_clk;
            // Registered edge strobe with the data bit captured alongside it
            r_fall      <= r_filt_clk_d & ~r_filt_clk;
            r_fall_data <= r_data_sync[1];
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t        r_state;
    state_t        w_next_state;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic [TW-1:0] r_to_cnt;
    logic          r_push;
    logic [7:0]    r_push_byte;
    logic          r_frame_err;
    logic          w_timeout;
    logic          w_frame_done;
    logic          w_good;
    logic          w_push;
    logic          w_err;
`ifdef PS2_BREAK_FILTER_EN
    logic          r_suppress;
`endif

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_frame_done = 1'b0;
        w_good       = 1'b0;
        w_push       = 1'b0;
        w_err        = 1'b0;
        w_timeout    = (r_state != ST_IDLE) && !r_fall &&
                       (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
        case (r_state)
            ST_IDLE: begin
                if (r_fall && !r_fall_data) begin
                    w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_fall && (r_bitcnt == 3'd7)) begin
                    w_next_state = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (r_fall) begin
                    w_next_state = ST_STOP;
                end
            end
            ST_STOP: begin
                if (r_fall) begin
                    w_next_state = ST_IDLE;
                    w_frame_done = 1'b1;
                    w_good       = ((^r_shift) ^ r_parity) & r_fall_data;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (w_timeout) begin
            w_next_state = ST_IDLE;
        end
        w_err = w_timeout | (w_frame_done & ~w_good);
`ifdef PS2_BREAK_FILTER_EN
        w_push = w_good && (r_shift != 8'hF0) && !r_suppress;
`else
        w_push = w_good;
`endif
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_to_cnt    <= '0;
            r_push      <= 1'b0;
            r_push_byte <= '0;
            r_frame_err <= 1'b0;
        end else begin
            if (r_fall) begin
                case (r_state)
                    ST_IDLE:   r_bitcnt <= '0;
                    ST_DATA: begin
                        r_shift  <= {r_fall_data, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                    end
                    ST_PARITY: r_parity <= r_fall_data;
                    default:   ;
                endcase
            end
            if ((r_state == ST_IDLE) || r_fall) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            r_push      <= w_push;
            r_push_byte <= r_shift;
            r_frame_err <= w_err;
        end
    end

`ifdef PS2_BREAK_FILTER_EN
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_suppress <= 1'b0;
        end else if (w_err) begin
            r_suppress <= 1'b0;
        end else if (w_good) begin
            // 0xF0 arms suppression; any other good byte consumes it
            r_suppress <= (r_shift == 8'hF0);
        end
    end
`endif

    // ------------------------------------------------------------------
    // Scan-code FIFO
    // ------------------------------------------------------------------
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_overflow;
    logic [PW-1:0] w_count;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;
    logic          w_ovf;

    always_comb begin
        w_count = r_wr_ptr - r_rd_ptr;
        w_full  = (w_count == PW'(FIFO_DEPTH));
        w_pop   = rd_en && (w_count != '0);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts
        w_wr    = r_push && (!w_full || w_pop);
        w_ovf   = r_push && w_full && !w_pop;
    end

    always_ff @(posedge Clock) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= r_push_byte;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end else if (clear_err) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign count     = w_count;
    assign valid     = (w_count != '0);
    assign data_out  = valid ? r_mem[r_rd_ptr[AW-1:0]] : 8'h00;
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_receptor_teclado.sv
// Self-checking bench for ps2_receptor_teclado: directed frames plus a
// randomized stream, compared against a byte-queue reference model.
module tb_ps2_receptor_teclado;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned FLEN  = 4;
    localparam int unsigned TOUT  = 600;
    localparam int unsigned HALF  = 20;

    logic Clock     = 1'b0;
    logic Reset_n   = 1'b0;
    logic ps2_clk   = 1'b1;
    logic ps2_data  = 1'b1;
    logic rd_en     = 1'b0;
    logic clear_err = 1'b0;
    logic [7:0] data_out;
    logic       valid;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic       overflow;
    logic       frame_err;

    int unsigned checks     = 0;
    int unsigned errors     = 0;
    int unsigned err_pulses = 0;

    // Reference model state
    logic [7:0]  q[$];
    logic        m_ovf  = 1'b0;
    logic        m_sup  = 1'b0;
    int unsigned m_errs = 0;

    ps2_receptor_teclado #(
        .FIFO_DEPTH     (DEPTH),
        .FILTER_LEN     (FLEN),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_en     (rd_en),
        .clear_err (clear_err),
        .data_out  (data_out),
        .valid     (valid),
        .count     (count),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #10 Clock = ~Clock;

    always @(negedge Clock) begin
        if (frame_err) err_pulses++;
    end

    initial begin
        #10ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [7:0] head;
        head = 8'h00;
        if (q.size() != 0) head = q[0];
        check({tag, ".count"}, 32'(count), 32'(q.size()));
        check({tag, ".valid"}, 32'(valid), 32'(q.size() != 0));
        check({tag, ".data"},  32'(data_out), 32'(head));
        check({tag, ".ovf"},   32'(overflow), 32'(m_ovf));
        check({tag, ".ferr"},  err_pulses, m_errs);
    endtask

    // Frame-level rules: odd parity over data+parity, stop must be 1,
    // good bytes queue unless full (overflow) or filtered as break codes.
    task automatic model_frame(input logic [7:0] b, input logic par, input logic stp);
        logic good;
        good = (((^b) ^ par) == 1'b1) && stp;
        if (!good) begin
            m_errs++;
            m_sup = 1'b0;
            return;
        end
`ifdef PS2_BREAK_FILTER_EN
        if (b == 8'hF0) begin
            m_sup = 1'b1;
            return;
        end
        if (m_sup) begin
            m_sup = 1'b0;
            return;
        end
`endif
        if (q.size() < DEPTH) q.push_back(b);
        else m_ovf = 1'b1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge Clock);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge Clock);
        ps2_clk = 1'b1;
    endtask

    // mode 0: plain, 1: check push latency on the stop bit,
    // 2: pulse rd_en on the very cycle the byte is pushed
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input int mode);
        logic [7:0] tmp;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        ps2_data = stp;
        repeat (HALF) @(negedge Clock);
        ps2_clk = 1'b0;
        repeat (FLEN + 4) @(negedge Clock);
        if (mode == 1) check("latency_before", 32'(valid), 32'd0);
        if (mode == 2) rd_en = 1'b1;
        @(negedge Clock);
        rd_en = 1'b0;
        if (mode == 1) check("latency_after", 32'(valid), 32'd1);
        repeat (HALF - FLEN - 5) @(negedge Clock);
        ps2_clk  = 1'b1;
        repeat (2 * HALF) @(negedge Clock);
        ps2_data = 1'b1;
        if (mode == 2) begin
            tmp = q.pop_front();
            q.push_back(b);
        end else begin
            model_frame(b, par, stp);
        end
    endtask

    task automatic pop();
        logic [7:0] tmp;
        @(negedge Clock);
        rd_en = 1'b1;
        @(negedge Clock);
        rd_en = 1'b0;
        if (q.size() != 0) tmp = q.pop_front();
    endtask

    task automatic do_clear();
        @(negedge Clock);
        clear_err = 1'b1;
        @(negedge Clock);
        clear_err = 1'b0;
        m_ovf = 1'b0;
    endtask

    function automatic logic good_par(input logic [7:0] b);
        return ~(^b);
    endfunction

    initial begin
        logic [7:0] b;
        logic       par;
        logic       stp;

        // Reset
        repeat (3) @(negedge Clock);
        check("rst.data",  32'(data_out),  32'd0);
        check("rst.valid", 32'(valid),     32'd0);
        check("rst.count", 32'(count),     32'd0);
        check("rst.ovf",   32'(overflow),  32'd0);
        check("rst.ferr",  32'(frame_err), 32'd0);
        Reset_n = 1'b1;
        repeat (5) @(negedge Clock);

        // Good frame 0x1C, push latency, then pop
        send_frame(8'h1C, 1'b0, 1'b1, 1);
        check("good1c.data", 32'(data_out), 32'h1C);
        check_state("good1c");
        pop();
        check_state("good1c_pop");
        pop();
        check_state("pop_empty");

        // Parity error
        send_frame(8'h1C, 1'b1, 1'b1, 0);
        check("parerr.pulses", err_pulses, 32'd1);
        check_state("parerr");

        // Overflow: 9 frames, no reads
        for (int i = 1; i <= 9; i++) begin
            b = 8'(i);
            send_frame(b, good_par(b), 1'b1, 0);
        end
        check("ovf.count", 32'(count), 32'd8);
        check("ovf.flag",  32'(overflow), 32'd1);
        check_state("ovf");
        for (int i = 1; i <= 8; i++) begin
            check("ovf.read", 32'(data_out), 32'(i));
            pop();
        end
        check_state("ovf_drained");
        do_clear();
        check("ovf.cleared", 32'(overflow), 32'd0);

        // Full FIFO with a pop on the same cycle as the 9th push
        for (int i = 1; i <= 8; i++) begin
            b = 8'(i);
            send_frame(b, good_par(b), 1'b1, 0);
        end
        send_frame(8'h09, good_par(8'h09), 1'b1, 2);
        check("simul.count", 32'(count), 32'd8);
        check("simul.ovf",   32'(overflow), 32'd0);
        check("simul.head",  32'(data_out), 32'h02);
        check_state("simul");
        while (q.size() != 0) pop();
        check_state("simul_drained");

        // Timeout after start + 4 data bits, then a good frame
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        ps2_data = 1'b1;
        repeat (TOUT + 100) @(negedge Clock);
        m_errs++;
        m_sup = 1'b0;
        check_state("timeout");
        send_frame(8'h5A, good_par(8'h5A), 1'b1, 0);
        check("after_to.data", 32'(data_out), 32'h5A);
        check_state("after_to");
        pop();

        // Reset mid-frame with a non-empty FIFO
        send_frame(8'h33, good_par(8'h33), 1'b1, 0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge Clock);
        Reset_n = 1'b0;
        @(negedge Clock);
        check("midrst.count", 32'(count), 32'd0);
        Reset_n = 1'b1;
        q.delete();
        m_ovf = 1'b0;
        m_sup = 1'b0;
        repeat (TOUT + 50) @(negedge Clock);
        check_state("midrst");

        // Break-code sequence
        send_frame(8'h1C, good_par(8'h1C), 1'b1, 0);
        send_frame(8'hF0, good_par(8'hF0), 1'b1, 0);
        send_frame(8'h1C, good_par(8'h1C), 1'b1, 0);
`ifdef PS2_BREAK_FILTER_EN
        check("brk.count", 32'(count), 32'd1);
`else
        check("brk.count", 32'(count), 32'd3);
`endif
        check_state("brk");
        while (q.size() != 0) pop();

        // Randomized stream
        for (int n = 0; n < 24; n++) begin
            b   = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) b = 8'hF0;
            par = good_par(b);
            if ($urandom_range(0, 4) == 0) par = ~par;
            stp = ($urandom_range(0, 7) != 0);
            send_frame(b, par, stp, 0);
            if ($urandom_range(0, 2) == 0) pop();
            if ($urandom_range(0, 7) == 0) do_clear();
            check_state("rand");
        end
        while (q.size() != 0) pop();
        check_state("rand_drained");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
